// File: rtl/imm_decode_stage_pkg.sv
// Shared field layout, decoded-entry type and occupancy encoding for the
// instruction decode stage that feeds the sign-extension unit.
package imm_decode_stage_pkg;

  localparam int OPC_W = 6;
  localparam int REG_W = 5;
  localparam int IMM_W = 16;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam int BYTE_OPC_BIT_DEF = 5;
  localparam int ZEXT_OPC_BIT_DEF = 4;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [IMM_W-1:0] imm;
    logic             sw;
    logic             zext;
  } dec_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Fetch-side and decode-side handshake bundle of the decode stage.
// master = fetch/consumer side, slave = the stage itself.
interface imm_decode_stage_if #(
  parameter int OPW  = 6,
  parameter int REGW = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            out_valid;
  logic            out_ready;
  logic [OPW-1:0]  opcode;
  logic [REGW-1:0] rs;
  logic [REGW-1:0] rt;
  logic [15:0]     imm;
  logic            sw;
  logic            zext;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, opcode, rs, rt, imm, sw, zext
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, opcode, rs, rt, imm, sw, zext
  );
endinterface

// File: rtl/imm_decode_stage_field_decode.sv
// Combinational slicer: raw instruction word to a pre-decoded entry,
// including the immediate width and zero-extension selects.
module imm_field_decode
  import imm_decode_stage_pkg::*;
#(
  parameter int BYTE_OPC_BIT = BYTE_OPC_BIT_DEF,
  parameter int ZEXT_OPC_BIT = ZEXT_OPC_BIT_DEF
) (
  input  logic [31:0] instr,
  output dec_entry_t  ent
);

  always_comb begin
    ent.opcode = instr[OPC_HI:OPC_LO];
    ent.rs     = instr[RS_HI:RS_LO];
    ent.rt     = instr[RT_HI:RT_LO];
    ent.imm    = instr[IMM_HI:IMM_LO];
    // byte-immediate opcodes clear sw so SignExtension uses only imm[7:0]
    ent.sw     = ~instr[OPC_LO+BYTE_OPC_BIT];
    ent.zext   = instr[OPC_LO+ZEXT_OPC_BIT];
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode stage: main output register plus one skid entry behind a registered
// in_ready, with branch flush and a saturating count of flushed entries.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int OPW          = OPC_W,
  parameter int REGW         = REG_W,
  parameter int BYTE_OPC_BIT = BYTE_OPC_BIT_DEF,
  parameter int ZEXT_OPC_BIT = ZEXT_OPC_BIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  output logic [15:0] drop_cnt,
  imm_decode_stage_if.slave bus
);

  occ_e       state_q, state_d;
  dec_entry_t dec_p0;
  dec_entry_t main_p1;
  dec_entry_t skid_p1;
  logic       in_ready_q;
  logic       acc, xfer;
  logic       load_main, load_skid, skid_to_main;
  logic [1:0] drop_inc;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  imm_field_decode #(
    .BYTE_OPC_BIT(BYTE_OPC_BIT),
    .ZEXT_OPC_BIT(ZEXT_OPC_BIT)
  ) u_dec (
    .instr(bus.instr),
    .ent  (dec_p0)
  );

  assign acc  = bus.in_valid && in_ready_q && !flush;
  assign xfer = (state_q != EMPTY) && bus.out_ready;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    drop_inc     = 2'd0;
    if (flush) begin
      state_d = EMPTY;
      // an entry leaving on this very edge was delivered, not dropped
      case (state_q)
        ONE:     drop_inc = xfer ? 2'd0 : 2'd1;
        TWO:     drop_inc = xfer ? 2'd1 : 2'd2;
        default: drop_inc = 2'd0;
      endcase
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (acc && xfer) begin
            load_main = 1'b1;
          end else if (acc) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (xfer) begin
            state_d      = ONE;
            skid_to_main = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // stage p0 -> p1: capture decoded word into main register or skid entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      drop_cnt   <= 16'd0;
      main_p1    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      drop_cnt   <= sat_add16(drop_cnt, drop_inc);
      if (load_main) begin
        main_p1 <= dec_p0;
      end else if (skid_to_main) begin
        main_p1 <= skid_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_p1 <= dec_p0;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.opcode    = OPW'(main_p1.opcode);
  assign bus.rs        = REGW'(main_p1.rs);
  assign bus.rt        = REGW'(main_p1.rt);
  assign bus.imm       = main_p1.imm;
  assign bus.sw        = main_p1.sw;
  assign bus.zext      = main_p1.zext;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed scenarios plus randomized handshakes,
// all checked against a queue model of the words held by the stage.
module tb_imm_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] drop_cnt;

  imm_decode_stage_if bus ();

  imm_decode_stage dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .drop_cnt(drop_cnt),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total;
  int          bad;
  int          delivered;
  logic [31:0] q[$];
  logic [15:0] exp_drop;
  logic        hold_prev;
  logic [63:0] snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Fields of a word as the consumer should see them: opcode/rs/rt are the
  // top half, imm the bottom half, sw clear for opcode bit 5, zext = opcode bit 4.
  function automatic logic [63:0] expect_of(input logic [31:0] w);
    return {30'd0, w, ~w[31], w[30]};
  endfunction

  function automatic logic [63:0] observed();
    return {30'd0, bus.opcode, bus.rs, bus.rt, bus.imm, bus.sw, bus.zext};
  endfunction

  function automatic logic [31:0] sext(input logic [15:0] i, input logic s);
    return s ? {{16{i[15]}}, i} : {{24{i[7]}}, i[7:0]};
  endfunction

  // Called at a falling edge: checks the present state, drives one cycle of
  // inputs, advances the model and waits for the next falling edge.
  task automatic step(input logic iv, input logic [31:0] w, input logic ordy, input logic fl);
    logic xf;
    logic ac;
    int   t;
    chk("out_valid", bus.out_valid, q.size() > 0);
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("drop_cnt", drop_cnt, exp_drop);
    if (q.size() > 0) chk("fields", observed(), expect_of(q[0]));
    if (hold_prev) chk("hold", observed(), snap);
    bus.in_valid  = iv;
    bus.instr     = w;
    bus.out_ready = ordy;
    flush         = fl;
    xf = (q.size() > 0) && ordy;
    ac = iv && (q.size() < 2) && !fl;
    hold_prev = (q.size() > 0) && !ordy;
    snap = observed();
    if (xf) begin
      void'(q.pop_front());
      delivered++;
    end
    if (fl) begin
      t = int'(exp_drop) + q.size();
      exp_drop = (t > 65535) ? 16'hFFFF : 16'(t);
      q.delete();
      hold_prev = 1'b0;
    end else if (ac) begin
      q.push_back(w);
    end
    @(negedge clk);
  endtask

  initial begin
    int target;
    int cyc;
    total = 0;
    bad = 0;
    delivered = 0;
    exp_drop = '0;
    hold_prev = 1'b0;
    snap = '0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_fields", observed(), 64'd0);
    chk("rst_drop", drop_cnt, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // single word, 1-cycle latency
    step(1'b1, 32'h0000_1234, 1'b1, 1'b0);
    chk("t1_valid", bus.out_valid, 1'b1);
    chk("t1_imm", bus.imm, 16'h1234);
    chk("t1_sw", bus.sw, 1'b1);
    chk("t1_zext", bus.zext, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("t1_gone", bus.out_valid, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // byte immediate feeding SignExtension
    step(1'b1, 32'h8000_00F0, 1'b1, 1'b0);
    chk("byte_sw", bus.sw, 1'b0);
    chk("byte_imm", bus.imm, 16'h00F0);
    chk("byte_sext", sext(bus.imm, bus.sw), 32'hFFFF_FFF0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // backpressure with three words
    step(1'b1, 32'h1111_0001, 1'b0, 1'b0);
    step(1'b1, 32'h2222_0002, 1'b0, 1'b0);
    chk("bp_ready_low", bus.in_ready, 1'b0);
    step(1'b1, 32'h3333_0003, 1'b0, 1'b0);
    chk("bp_front", bus.imm, 16'h0001);
    step(1'b1, 32'h3333_0003, 1'b0, 1'b0);
    step(1'b1, 32'h3333_0003, 1'b1, 1'b0);
    step(1'b1, 32'h3333_0003, 1'b1, 1'b0);
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("bp_all_out", delivered, 5);

    // flush while full with a word on offer
    step(1'b1, 32'h4444_0004, 1'b0, 1'b0);
    step(1'b1, 32'h5555_0005, 1'b0, 1'b0);
    step(1'b1, 32'h6666_0006, 1'b0, 1'b1);
    chk("fl_valid", bus.out_valid, 1'b0);
    chk("fl_ready", bus.in_ready, 1'b1);
    chk("fl_drop", drop_cnt, 16'd2);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("fl_not_taken", bus.out_valid, 1'b0);

    // asynchronous reset while full
    step(1'b1, 32'h7777_0007, 1'b0, 1'b0);
    step(1'b1, 32'h8888_0008, 1'b0, 1'b0);
    #2 rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_ready", bus.in_ready, 1'b1);
    chk("arst_drop", drop_cnt, 16'd0);
    chk("arst_fields", observed(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_drop = '0;
    hold_prev = 1'b0;
    @(negedge clk);

    // randomized handshakes with occasional flush
    target = delivered + 1000;
    cyc = 0;
    while (delivered < target && cyc < 20000) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 63) == 0);
      cyc++;
    end
    chk("rand_words", delivered >= target, 1'b1);
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
